// File: rtl/bp_tlb_arbiter.sv
// TLB port arbiter: fetch/load-store lookups, PTE fills and flush sequencing.
// Fills win unless a read has been starved for fill_burst_p grants.
module bp_tlb_arbiter #(
  parameter int vtag_width_p  = 28,
  parameter int entry_width_p = 40,
  parameter int fill_burst_p  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     req0_v_i,
  input  logic [vtag_width_p-1:0]  req0_vtag_i,
  output logic                     req0_ready_o,
  output logic                     resp0_v_o,
  output logic                     resp0_miss_o,
  output logic [entry_width_p-1:0] resp0_entry_o,

  input  logic                     req1_v_i,
  input  logic [vtag_width_p-1:0]  req1_vtag_i,
  output logic                     req1_ready_o,
  output logic                     resp1_v_o,
  output logic                     resp1_miss_o,
  output logic [entry_width_p-1:0] resp1_entry_o,

  input  logic                     fill_v_i,
  input  logic [vtag_width_p-1:0]  fill_vtag_i,
  input  logic [entry_width_p-1:0] fill_entry_i,
  output logic                     fill_ready_o,

  input  logic                     flush_i,
  output logic                     flush_busy_o,

  output logic                     tlb_v_o,
  output logic                     tlb_w_o,
  output logic [vtag_width_p-1:0]  tlb_vtag_o,
  output logic [entry_width_p-1:0] tlb_entry_o,
  output logic                     tlb_flush_o,
  input  logic                     tlb_v_i,
  input  logic                     tlb_miss_v_i,
  input  logic [entry_width_p-1:0] tlb_entry_i
);

  localparam int sw_lp = (fill_burst_p > 0) ? $clog2(fill_burst_p + 1) : 1;
  localparam logic [sw_lp-1:0] burst_lp = sw_lp'(fill_burst_p);

  typedef enum logic [1:0] {
    READY = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_r;
  logic             rr_r;
  logic [sw_lp-1:0] streak_r;
  logic             owner_v_r;
  logic             owner_id_r;

  logic any_req;
  logic open;
  logic starved;
  logic fill_win;
  logic read_win;
  logic read_id;
  logic unused_tlb_v;

  // Hit strobe is implied by the response cycle; miss alone qualifies it.
  assign unused_tlb_v = tlb_v_i;

  assign any_req  = req0_v_i | req1_v_i;
  assign open     = reset_n_i & (state_r == READY) & ~flush_i;
  assign starved  = any_req & (streak_r == burst_lp);
  assign read_id  = (req0_v_i & req1_v_i) ? rr_r : req1_v_i;
  assign fill_win = open & fill_v_i & ~starved;
  assign read_win = open & any_req & ~fill_win;

  assign fill_ready_o = fill_win;
  assign req0_ready_o = read_win & ~read_id;
  assign req1_ready_o = read_win & read_id;

  assign tlb_v_o     = fill_win | read_win;
  assign tlb_w_o     = fill_win;
  assign tlb_entry_o = fill_win ? fill_entry_i : '0;
  assign tlb_flush_o = reset_n_i & (state_r == FLUSH);

  always_comb begin
    tlb_vtag_o = '0;
    unique case (1'b1)
      fill_win:             tlb_vtag_o = fill_vtag_i;
      read_win & ~read_id:  tlb_vtag_o = req0_vtag_i;
      read_win &  read_id:  tlb_vtag_o = req1_vtag_i;
      default:              tlb_vtag_o = '0;
    endcase
  end

  assign flush_busy_o =
    reset_n_i & ((state_r != READY) | flush_i);

  assign resp0_v_o     = reset_n_i & owner_v_r & ~owner_id_r;
  assign resp1_v_o     = reset_n_i & owner_v_r & owner_id_r;
  assign resp0_miss_o  = resp0_v_o & tlb_miss_v_i;
  assign resp1_miss_o  = resp1_v_o & tlb_miss_v_i;
  assign resp0_entry_o = resp0_v_o ? tlb_entry_i : '0;
  assign resp1_entry_o = resp1_v_o ? tlb_entry_i : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= READY;
      rr_r       <= 1'b0;
      streak_r   <= '0;
      owner_v_r  <= 1'b0;
      owner_id_r <= 1'b0;
    end else begin
      unique case (state_r)
        READY:   state_r <= flush_i ? FLUSH : READY;
        FLUSH:   state_r <= flush_i ? FLUSH : DRAIN;
        DRAIN:   state_r <= flush_i ? FLUSH : READY;
        default: state_r <= READY;
      endcase

      owner_v_r <= read_win;
      if (read_win) begin
        owner_id_r <= read_id;
        rr_r       <= ~read_id;
      end

      if (read_win || !any_req)
        streak_r <= '0;
      else if (fill_win && streak_r != burst_lp)
        streak_r <= streak_r + sw_lp'(1);
    end
  end

endmodule

// File: tb/tb_bp_tlb_arbiter.sv
// Directed bench for bp_tlb_arbiter; read responses are
// checked against a scoreboard filled when grants are expected.
module tb_bp_tlb_arbiter;

  localparam logic [27:0] V0 = 28'h10;
  localparam logic [27:0] V1 = 28'h20;
  localparam logic [27:0] VF = 28'h33;
  localparam logic [39:0] FE = 40'h12_3456_789A;

  logic        clk;
  logic        reset_n_i;
  logic        req0_v_i, req1_v_i, fill_v_i, flush_i;
  logic [27:0] req0_vtag_i, req1_vtag_i, fill_vtag_i;
  logic [39:0] fill_entry_i, tlb_entry_i;
  logic        tlb_v_i, tlb_miss_v_i;
  logic        req0_ready_o, req1_ready_o, fill_ready_o;
  logic        resp0_v_o, resp1_v_o, resp0_miss_o, resp1_miss_o;
  logic [39:0] resp0_entry_o, resp1_entry_o;
  logic        flush_busy_o, tlb_v_o, tlb_w_o, tlb_flush_o;
  logic [27:0] tlb_vtag_o;
  logic [39:0] tlb_entry_o;

  typedef struct packed {
    logic        v;
    logic        id;
    logic        miss;
    logic [39:0] entry;
  } rsp_t;

  rsp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  bp_tlb_arbiter dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req0_v_i(req0_v_i), .req0_vtag_i(req0_vtag_i),
    .req0_ready_o(req0_ready_o), .resp0_v_o(resp0_v_o),
    .resp0_miss_o(resp0_miss_o), .resp0_entry_o(resp0_entry_o),
    .req1_v_i(req1_v_i), .req1_vtag_i(req1_vtag_i),
    .req1_ready_o(req1_ready_o), .resp1_v_o(resp1_v_o),
    .resp1_miss_o(resp1_miss_o), .resp1_entry_o(resp1_entry_o),
    .fill_v_i(fill_v_i), .fill_vtag_i(fill_vtag_i),
    .fill_entry_i(fill_entry_i), .fill_ready_o(fill_ready_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .tlb_v_o(tlb_v_o), .tlb_w_o(tlb_w_o),
    .tlb_vtag_o(tlb_vtag_o), .tlb_entry_o(tlb_entry_o),
    .tlb_flush_o(tlb_flush_o), .tlb_v_i(tlb_v_i),
    .tlb_miss_v_i(tlb_miss_v_i), .tlb_entry_i(tlb_entry_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] tdata(input int c);
    return 40'hA5_0000_0000 | 40'(c);
  endfunction

  function automatic logic tmiss(input int c);
    return (c % 3) == 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_tlb();
    tlb_entry_i  = tdata(cyc);
    tlb_miss_v_i = tmiss(cyc);
    tlb_v_i      = ~tmiss(cyc);
  endtask

  task automatic push_none();
    rsp_t e;
    e = '0;
    sbq.push_back(e);
  endtask

  task automatic check_resp();
    rsp_t e;
    logic v0, v1;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 64'(sbq.size()), 64'd1);
      return;
    end
    e  = sbq.pop_front();
    v0 = e.v & ~e.id;
    v1 = e.v & e.id;
    chk("resp0_v", resp0_v_o, v0);
    chk("resp1_v", resp1_v_o, v1);
    chk("resp0_miss", resp0_miss_o, v0 & e.miss);
    chk("resp1_miss", resp1_miss_o, v1 & e.miss);
    chk("resp0_entry", resp0_entry_o, v0 ? e.entry : 40'h0);
    chk("resp1_entry", resp1_entry_o, v1 ? e.entry : 40'h0);
  endtask

  // eg = {fill, req1, req0} expected grants
  task automatic step(input logic f, input logic r0,
                      input logic r1, input logic fl,
                      input logic [2:0] eg,
                      input logic ef, input logic eb);
    rsp_t        e;
    logic [27:0] ev;
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    fill_v_i  = f;
    req0_v_i  = r0;
    req1_v_i  = r1;
    flush_i   = fl;
    drive_tlb();
    @(negedge clk);
    check_resp();
    chk("grant", {fill_ready_o, req1_ready_o, req0_ready_o}, eg);
    chk("tlb_v", tlb_v_o, |eg);
    chk("tlb_w", tlb_w_o, eg[2]);
    ev = eg[2] ? VF : eg[1] ? V1 : eg[0] ? V0 : 28'h0;
    chk("tlb_vtag", tlb_vtag_o, ev);
    chk("tlb_entry", tlb_entry_o, eg[2] ? FE : 40'h0);
    chk("tlb_flush", tlb_flush_o, ef);
    chk("flush_busy", flush_busy_o, eb);
    e.v     = eg[0] | eg[1];
    e.id    = eg[1];
    e.miss  = tmiss(cyc + 1);
    e.entry = tdata(cyc + 1);
    sbq.push_back(e);
    cyc++;
  endtask

  task automatic rst();
    @(posedge clk);
    #1;
    reset_n_i = 1'b0;
    fill_v_i  = 1'b1;
    req0_v_i  = 1'b1;
    req1_v_i  = 1'b1;
    flush_i   = 1'b1;
    drive_tlb();
    @(negedge clk);
    chk("rst_ctl", {fill_ready_o, req1_ready_o, req0_ready_o,
                    resp0_v_o, resp1_v_o, resp0_miss_o,
                    resp1_miss_o, flush_busy_o, tlb_v_o,
                    tlb_w_o, tlb_flush_o}, 64'h0);
    chk("rst_vtag", tlb_vtag_o, 64'h0);
    chk("rst_tlb_entry", tlb_entry_o, 64'h0);
    chk("rst_resp0_entry", resp0_entry_o, 64'h0);
    chk("rst_resp1_entry", resp1_entry_o, 64'h0);
    sbq.delete();
    push_none();
    cyc++;
  endtask

  initial begin
    reset_n_i    = 1'b0;
    req0_v_i     = 1'b0;
    req1_v_i     = 1'b0;
    fill_v_i     = 1'b0;
    flush_i      = 1'b0;
    req0_vtag_i  = V0;
    req1_vtag_i  = V1;
    fill_vtag_i  = VF;
    fill_entry_i = FE;
    tlb_v_i      = 1'b0;
    tlb_miss_v_i = 1'b0;
    tlb_entry_i  = '0;

    rst();
    rst();

    // both readers: round-robin 0,1,0,1
    step(0, 1, 1, 0, 3'b001, 0, 0);
    step(0, 1, 1, 0, 3'b010, 0, 0);
    step(0, 1, 1, 0, 3'b001, 0, 0);
    step(0, 1, 1, 0, 3'b010, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0);

    // fill burst against a waiting req0
    step(1, 1, 0, 0, 3'b100, 0, 0);
    step(1, 1, 0, 0, 3'b100, 0, 0);
    step(1, 1, 0, 0, 3'b100, 0, 0);
    step(1, 1, 0, 0, 3'b100, 0, 0);
    step(1, 1, 0, 0, 3'b001, 0, 0);
    step(1, 1, 0, 0, 3'b100, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0);

    // fills with no reader pending do not build a streak
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 3'b100, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 0, 3'b100, 0, 0);
    step(1, 0, 1, 0, 3'b010, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0);

    // flush while a req1 response is in flight
    step(0, 0, 1, 0, 3'b010, 0, 0);
    step(0, 0, 1, 1, 3'b000, 0, 1);
    step(0, 0, 1, 0, 3'b000, 1, 1);
    step(1, 0, 1, 0, 3'b000, 0, 1);
    step(0, 0, 1, 0, 3'b010, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0);

    // second flush pulse landing in DRAIN
    step(0, 0, 0, 1, 3'b000, 0, 1);
    step(0, 1, 0, 0, 3'b000, 1, 1);
    step(1, 1, 0, 1, 3'b000, 0, 1);
    step(0, 1, 0, 0, 3'b000, 1, 1);
    step(0, 1, 0, 0, 3'b000, 0, 1);
    step(0, 1, 0, 0, 3'b001, 0, 0);

    // flush held across FLUSH re-enters FLUSH
    step(0, 0, 0, 1, 3'b000, 0, 1);
    step(1, 0, 0, 1, 3'b000, 1, 1);
    step(0, 0, 0, 0, 3'b000, 1, 1);
    step(0, 0, 0, 0, 3'b000, 0, 1);
    step(0, 1, 1, 0, 3'b010, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0);

    // reset on the response cycle drops the response
    step(0, 1, 0, 0, 3'b001, 0, 0);
    rst();
    step(0, 0, 0, 0, 3'b000, 0, 0);
    step(0, 1, 1, 0, 3'b001, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
